// File: rtl/key_pkg.sv
// Shared types and helpers for the serial key loader.
package key_pkg;

  localparam int KEY_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY,
    CHECK
  } key_ld_state_t;

  function automatic logic key_parity(input logic [KEY_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/key_shift_reg.sv
// Shadow register and bit counter for the serial key; bits enter at the MSB
// and move down, so the first bit received ends up in bit 0.
module key_shift_reg
  import key_pkg::*;
#(
  parameter int KEY_W = key_pkg::KEY_W,
  parameter int CNT_W = $clog2(KEY_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             shift_en_i,
  input  logic             data_i,
  output logic [KEY_W-1:0] shadow_o,
  output logic             count_full_o
);

  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    shadow_d = shadow_q;
    count_d  = count_q;
    if (clear_i) begin
      shadow_d = '0;
      count_d  = '0;
    end else if (shift_en_i) begin
      shadow_d = {data_i, shadow_q[KEY_W-1:1]};
      count_d  = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      count_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  // Asserted on the shift that completes the key, so the FSM can leave
  // SHIFT without an idle cycle between the last key bit and the parity bit.
  assign count_full_o = shift_en_i && (count_q == CNT_W'(KEY_W - 1));
  assign shadow_o     = shadow_q;

endmodule

// File: rtl/key_loader.sv
// Serial key loader: collects KEY_W key bits plus an even-parity bit and
// commits the key to the parallel outputs only after the parity check passes.
module key_loader
  import key_pkg::*;
#(
  parameter int KEY_W = key_pkg::KEY_W,
  parameter int CNT_W = $clog2(KEY_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             key_clear,
  input  logic             ser_valid,
  input  logic             ser_data,
  output logic             ser_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             load_err,
  output logic             busy
);

  key_ld_state_t    state_q, state_d;
  logic             parity_q, parity_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             valid_q, valid_d;

  logic             sh_clear, sh_shift, count_full;
  logic             par_cap, commit;
  logic [KEY_W-1:0] shadow;

  key_shift_reg #(
    .KEY_W(KEY_W),
    .CNT_W(CNT_W)
  ) u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (sh_clear),
    .shift_en_i  (sh_shift),
    .data_i      (ser_data),
    .shadow_o    (shadow),
    .count_full_o(count_full)
  );

  always_comb begin
    state_d   = state_q;
    ser_ready = 1'b0;
    busy      = 1'b1;
    load_err  = 1'b0;
    sh_clear  = 1'b0;
    sh_shift  = 1'b0;
    par_cap   = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (load_start) begin
          sh_clear = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        ser_ready = 1'b1;
        // A restart takes priority and discards any bit offered this cycle.
        if (load_start) begin
          sh_clear = 1'b1;
        end else if (ser_valid) begin
          sh_shift = 1'b1;
          if (count_full) state_d = PARITY;
        end
      end
      PARITY: begin
        ser_ready = 1'b1;
        if (load_start) begin
          sh_clear = 1'b1;
          state_d  = SHIFT;
        end else if (ser_valid) begin
          par_cap = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if ((key_parity(shadow) ^ parity_q) == 1'b0) commit = 1'b1;
        else load_err = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    parity_d = par_cap ? ser_data : parity_q;
    key_d    = key_q;
    valid_d  = valid_q;
    if (key_clear) begin
      key_d   = '0;
      valid_d = 1'b0;
    end else if (commit) begin
      key_d   = shadow;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      parity_q <= 1'b0;
      key_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      key_q    <= key_d;
      valid_q  <= valid_d;
    end
  end

  assign key_out   = key_q;
  assign key_valid = valid_q;

endmodule
